// File: rtl/alu_decode_pkg.sv
// Shared op codes, opcode constants and the decoded-instruction record for
// the decode stage.
package alu_decode_pkg;

    // Widest supported datapath; narrower configurations use the low bits.
    localparam int XLEN_MAX = 64;

    localparam logic [4:0] ALU_NOP    = 5'd0;
    localparam logic [4:0] ALU_ADD    = 5'd1;
    localparam logic [4:0] ALU_SUB    = 5'd2;
    localparam logic [4:0] ALU_SLL    = 5'd3;
    localparam logic [4:0] ALU_SLT    = 5'd4;
    localparam logic [4:0] ALU_SLTU   = 5'd5;
    localparam logic [4:0] ALU_XOR    = 5'd6;
    localparam logic [4:0] ALU_SRL    = 5'd7;
    localparam logic [4:0] ALU_SRA    = 5'd8;
    localparam logic [4:0] ALU_OR     = 5'd9;
    localparam logic [4:0] ALU_AND    = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd11;
    localparam logic [4:0] ALU_MULH   = 5'd12;
    localparam logic [4:0] ALU_MULHSU = 5'd13;
    localparam logic [4:0] ALU_MULHU  = 5'd14;
    localparam logic [4:0] ALU_DIV    = 5'd15;
    localparam logic [4:0] ALU_DIVU   = 5'd16;
    localparam logic [4:0] ALU_REM    = 5'd17;
    localparam logic [4:0] ALU_REMU   = 5'd18;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQ   = 3'd1;
    localparam logic [2:0] BR_NE   = 3'd2;
    localparam logic [2:0] BR_LT   = 3'd3;
    localparam logic [2:0] BR_GE   = 3'd4;
    localparam logic [2:0] BR_LTU  = 3'd5;
    localparam logic [2:0] BR_GEU  = 3'd6;

    localparam logic [2:0] MEM_NONE = 3'd0;
    localparam logic [2:0] MEM_B    = 3'd1;
    localparam logic [2:0] MEM_H    = 3'd2;
    localparam logic [2:0] MEM_W    = 3'd3;
    localparam logic [2:0] MEM_BU   = 3'd4;
    localparam logic [2:0] MEM_HU   = 3'd5;
    localparam logic [2:0] MEM_D    = 3'd6;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [4:0]          alu_op;
        logic [2:0]          br_op;
        logic [2:0]          mem_op;
        logic                is_store;
        logic [XLEN_MAX-1:0] imm;
        logic                use_imm;
        logic                illegal;
    } dec_t;

    function automatic logic [XLEN_MAX-1:0] sext12(input logic [11:0] v);
        return {{(XLEN_MAX-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational RV32I/RV64I (+optional M) decoder: raw instruction to dec_t.
// Immediates are sign-extended to XLEN_MAX; the top keeps the low XLEN bits.
module rv_decode_comb
    import alu_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int EN_M = 0
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output dec_t            dec
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("rv_decode_comb: XLEN must be 32 or 64");
    end

    logic [6:0]          opcode;
    logic [6:0]          funct7;
    logic [2:0]          funct3;
    logic [XLEN_MAX-1:0] imm_i;
    logic [XLEN_MAX-1:0] imm_s;
    logic [XLEN_MAX-1:0] imm_b;
    logic [XLEN_MAX-1:0] shamt;
    logic                shift_hi_zero;
    logic                shift_hi_alt;
    logic                unused_rs1;

    assign opcode     = instr[6:0];
    assign funct3     = instr[14:12];
    assign funct7     = instr[31:25];
    assign imm_i      = sext12(instr[31:20]);
    assign imm_s      = sext12({instr[31:25], instr[11:7]});
    assign imm_b      = {{(XLEN_MAX-13){instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
    assign unused_rs1 = ^instr[19:15];

    // Shift-immediate qualifier width depends on how wide shamt is.
    if (XLEN == 64) begin : g_sh64
        assign shift_hi_zero = (instr[31:26] == 6'b000000);
        assign shift_hi_alt  = (instr[31:26] == 6'b010000);
        assign shamt         = {{(XLEN_MAX-6){1'b0}}, instr[25:20]};
    end else begin : g_sh32
        assign shift_hi_zero = (funct7 == F7_BASE);
        assign shift_hi_alt  = (funct7 == F7_ALT);
        assign shamt         = {{(XLEN_MAX-5){1'b0}}, instr[24:20]};
    end

    logic [4:0]          alu_op;
    logic [2:0]          br_op;
    logic [2:0]          mem_op;
    logic                is_store;
    logic [XLEN_MAX-1:0] imm;
    logic                use_imm;
    logic                illegal;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        alu_op   = ALU_NOP;
        br_op    = BR_NONE;
        mem_op   = MEM_NONE;
        is_store = 1'b0;
        imm      = '0;
        use_imm  = 1'b0;
        illegal  = 1'b0;

        case (opcode)
            OPC_OP: begin
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000: alu_op = ALU_ADD;
                            3'b001: alu_op = ALU_SLL;
                            3'b010: alu_op = ALU_SLT;
                            3'b011: alu_op = ALU_SLTU;
                            3'b100: alu_op = ALU_XOR;
                            3'b101: alu_op = ALU_SRL;
                            3'b110: alu_op = ALU_OR;
                            3'b111: alu_op = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == 3'b000)      alu_op  = ALU_SUB;
                        else if (funct3 == 3'b101) alu_op  = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                    F7_MULDIV: begin
                        if (EN_M != 0) begin
                            case (funct3)
                                3'b000: alu_op = ALU_MUL;
                                3'b001: alu_op = ALU_MULH;
                                3'b010: alu_op = ALU_MULHSU;
                                3'b011: alu_op = ALU_MULHU;
                                3'b100: alu_op = ALU_DIV;
                                3'b101: alu_op = ALU_DIVU;
                                3'b110: alu_op = ALU_REM;
                                3'b111: alu_op = ALU_REMU;
                            endcase
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                use_imm = 1'b1;
                imm     = imm_i;
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    3'b001: begin
                        imm = shamt;
                        if (shift_hi_zero) alu_op  = ALU_SLL;
                        else               illegal = 1'b1;
                    end
                    3'b101: begin
                        imm = shamt;
                        if (shift_hi_zero)     alu_op  = ALU_SRL;
                        else if (shift_hi_alt) alu_op  = ALU_SRA;
                        else                   illegal = 1'b1;
                    end
                endcase
            end
            OPC_LOAD: begin
                alu_op  = ALU_ADD;
                use_imm = 1'b1;
                imm     = imm_i;
                case (funct3)
                    3'b000: mem_op = MEM_B;
                    3'b001: mem_op = MEM_H;
                    3'b010: mem_op = MEM_W;
                    3'b011: if (XLEN == 64) mem_op = MEM_D; else illegal = 1'b1;
                    3'b100: mem_op = MEM_BU;
                    3'b101: mem_op = MEM_HU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                alu_op   = ALU_ADD;
                use_imm  = 1'b1;
                is_store = 1'b1;
                imm      = imm_s;
                case (funct3)
                    3'b000: mem_op = MEM_B;
                    3'b001: mem_op = MEM_H;
                    3'b010: mem_op = MEM_W;
                    3'b011: if (XLEN == 64) mem_op = MEM_D; else illegal = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                alu_op = ALU_SUB;
                imm    = imm_b;
                case (funct3)
                    3'b000: br_op = BR_EQ;
                    3'b001: br_op = BR_NE;
                    3'b100: br_op = BR_LT;
                    3'b101: br_op = BR_GE;
                    3'b110: br_op = BR_LTU;
                    3'b111: br_op = BR_GEU;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            alu_op   = ALU_NOP;
            br_op    = BR_NONE;
            mem_op   = MEM_NONE;
            is_store = 1'b0;
            imm      = '0;
            use_imm  = 1'b0;
        end

        dec.pc       = XLEN_MAX'(pc);
        dec.alu_op   = alu_op;
        dec.br_op    = br_op;
        dec.mem_op   = mem_op;
        dec.is_store = is_store;
        dec.imm      = imm;
        dec.use_imm  = use_imm;
        dec.illegal  = illegal;
    end

endmodule

// File: rtl/alu_decode_pipe.sv
// Registered decode stage: decoder feeding a two-slot skid buffer (OUT + SKID)
// with flush, plus a saturating count of accepted illegal instructions.
module alu_decode_pipe
    import alu_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int EN_M  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_alu_op,
    output logic [2:0]       out_br_op,
    output logic [2:0]       out_mem_op,
    output logic             out_is_store,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_use_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [1:0] {EMPTY, FULL1, FULL2} state_t;

    state_t     state;
    dec_t       dec_in;
    dec_t       out_q;
    dec_t       skid_q;
    logic       out_valid_q;
    logic       in_ready_q;
    logic       accept;
    logic       drain;
    logic [CNT_W-1:0] cnt_q;
    logic       unused_hi;

    rv_decode_comb #(.XLEN(XLEN), .EN_M(EN_M)) u_dec (
        .instr (in_instr),
        .pc    (in_pc),
        .dec   (dec_in)
    );

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data slots are reset too, because every output field
            // must read 0 out of reset, not just the valid flags.
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_q       <= '0;
            skid_q      <= '0;
        end else if (flush) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_q       <= dec_in;
                        out_valid_q <= 1'b1;
                        state       <= FULL1;
                    end
                end
                FULL1: begin
                    if (accept && drain) begin
                        out_q <= dec_in;
                    end else if (accept) begin
                        skid_q     <= dec_in;
                        in_ready_q <= 1'b0;
                        state      <= FULL2;
                    end else if (drain) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                FULL2: begin
                    // in_ready is low here, so only a drain can move us.
                    if (drain) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= FULL1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && dec_in.illegal && !flush && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = out_q.pc[XLEN-1:0];
    assign out_alu_op   = out_q.alu_op;
    assign out_br_op    = out_q.br_op;
    assign out_mem_op   = out_q.mem_op;
    assign out_is_store = out_q.is_store;
    assign out_imm      = out_q.imm[XLEN-1:0];
    assign out_use_imm  = out_q.use_imm;
    assign out_illegal  = out_q.illegal;
    assign illegal_cnt  = cnt_q;
    assign unused_hi    = ^{out_q.pc, out_q.imm};

endmodule

// File: tb/tb_alu_decode_pipe.sv
// Drives two configurations (RV32 without M, RV64 with M) with identical
// traffic and compares both against a table-driven decode and queue model.
module tb_alu_decode_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_st, a_use, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_alu;
    logic [2:0]  a_br, a_mem;
    logic [3:0]  a_cnt;

    logic        b_in_ready, b_out_valid, b_st, b_use, b_ill;
    logic [63:0] b_pc, b_imm;
    logic [4:0]  b_alu;
    logic [2:0]  b_br, b_mem;
    logic [15:0] b_cnt;

    always #5 clk = ~clk;

    alu_decode_pipe #(.XLEN(32), .EN_M(0), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_alu_op(a_alu), .out_br_op(a_br), .out_mem_op(a_mem),
        .out_is_store(a_st), .out_imm(a_imm), .out_use_imm(a_use),
        .out_illegal(a_ill), .illegal_cnt(a_cnt)
    );

    alu_decode_pipe #(.XLEN(64), .EN_M(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .out_alu_op(b_alu), .out_br_op(b_br), .out_mem_op(b_mem),
        .out_is_store(b_st), .out_imm(b_imm), .out_use_imm(b_use),
        .out_illegal(b_ill), .illegal_cnt(b_cnt)
    );

    typedef struct {
        int          alu;
        int          br;
        int          mem;
        bit          st;
        logic [63:0] imm;
        bit          use_imm;
        bit          ill;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } entry_t;

    entry_t q[$];
    int     cnt_a = 0;
    int     cnt_b = 0;
    int     errors = 0;
    int     checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] ins, input int xlen, input bit en_m);
        exp_t   e;
        longint sx;
        int     f3, f7, hi, sh;
        int     base_r[8] = '{1, 3, 4, 5, 6, 7, 9, 10};
        int     opimm[8]  = '{1, 0, 4, 5, 6, 0, 9, 10};
        int     ld_mem[8] = '{1, 2, 3, 6, 4, 5, 0, 0};
        int     br_tab[8] = '{1, 2, 0, 0, 3, 4, 5, 6};
        e  = '{alu: 0, br: 0, mem: 0, st: 0, imm: 64'd0, use_imm: 0, ill: 0};
        sx = longint'($signed(ins));
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        case (ins[6:0])
            7'h33: begin
                if (f7 == 0)                                 e.alu = base_r[f3];
                else if (f7 == 32 && (f3 == 0 || f3 == 5))   e.alu = (f3 == 0) ? 2 : 8;
                else if (f7 == 1 && en_m)                    e.alu = 11 + f3;
                else                                         e.ill = 1;
            end
            7'h13: begin
                e.use_imm = 1;
                e.imm     = sx >>> 20;
                if (f3 == 1 || f3 == 5) begin
                    hi    = int'(ins >> ((xlen == 64) ? 26 : 25));
                    sh    = int'(ins >> 20) & (xlen - 1);
                    e.imm = 64'(sh);
                    if (hi == 0)                                   e.alu = (f3 == 1) ? 3 : 7;
                    else if (f3 == 5 && hi == ((xlen == 64) ? 16 : 32)) e.alu = 8;
                    else                                           e.ill = 1;
                end else begin
                    e.alu = opimm[f3];
                end
            end
            7'h03: begin
                e.alu = 1; e.use_imm = 1; e.imm = sx >>> 20;
                e.mem = ld_mem[f3];
                if (e.mem == 0 || (e.mem == 6 && xlen != 64)) e.ill = 1;
            end
            7'h23: begin
                e.alu = 1; e.use_imm = 1; e.st = 1;
                e.imm = ((sx >>> 25) << 5) | longint'(ins[11:7]);
                if (f3 <= 2)                     e.mem = f3 + 1;
                else if (f3 == 3 && xlen == 64)  e.mem = 6;
                else                             e.ill = 1;
            end
            7'h63: begin
                e.alu = 2;
                e.imm = ((sx >>> 31) << 12) | (longint'(ins[7]) << 11)
                      | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
                e.br  = br_tab[f3];
                if (e.br == 0) e.ill = 1;
            end
            default: e.ill = 1;
        endcase
        if (e.ill) e = '{alu: 0, br: 0, mem: 0, st: 0, imm: 64'd0, use_imm: 0, ill: 1};
        if (xlen == 32) e.imm = e.imm & 64'h0000_0000_FFFF_FFFF;
        return e;
    endfunction

    task automatic check_entry(input entry_t ent);
        exp_t ea, eb;
        ea = ref_dec(ent.ins, 32, 1'b0);
        eb = ref_dec(ent.ins, 64, 1'b1);
        check("a_pc", a_pc, ent.pc[31:0]);
        check("a_alu", a_alu, ea.alu);
        check("a_br", a_br, ea.br);
        check("a_mem", a_mem, ea.mem);
        check("a_store", a_st, ea.st);
        check("a_imm", a_imm, ea.imm);
        check("a_use_imm", a_use, ea.use_imm);
        check("a_illegal", a_ill, ea.ill);
        check("b_pc", b_pc, ent.pc);
        check("b_alu", b_alu, eb.alu);
        check("b_br", b_br, eb.br);
        check("b_mem", b_mem, eb.mem);
        check("b_store", b_st, eb.st);
        check("b_imm", b_imm, eb.imm);
        check("b_use_imm", b_use, eb.use_imm);
        check("b_illegal", b_ill, eb.ill);
    endtask

    // Called just after a falling edge; applies inputs for the next rising
    // edge, updates the model, and checks handshake state one edge later.
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                         input bit rdy, input bit fl, output bit acc);
        exp_t e;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
        acc = v && (q.size() < 2) && !fl;
        if (!fl && rdy && q.size() > 0) check_entry(q.pop_front());
        if (fl) q.delete();
        if (acc) begin
            q.push_back('{ins: ins, pc: pc});
            e = ref_dec(ins, 32, 1'b0);
            if (e.ill && cnt_a < 15) cnt_a++;
            e = ref_dec(ins, 64, 1'b1);
            if (e.ill && cnt_b < 65535) cnt_b++;
        end
        @(negedge clk);
        check("a_out_valid", a_out_valid, q.size() > 0);
        check("a_in_ready", a_in_ready, q.size() < 2);
        check("b_out_valid", b_out_valid, q.size() > 0);
        check("b_in_ready", b_in_ready, q.size() < 2);
        check("a_illegal_cnt", a_cnt, cnt_a);
        check("b_illegal_cnt", b_cnt, cnt_b);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops[5] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
        logic [6:0]  f7s[3] = '{7'h00, 7'h20, 7'h01};
        int          k;
        r = $urandom();
        k = $urandom_range(0, 5);
        if (k < 5) r[6:0] = ops[k];
        k = $urandom_range(0, 3);
        if (k < 3) r[31:25] = f7s[k];
        return r;
    endfunction

    task automatic drain_all(input string tag);
        bit acc;
        for (int i = 0; i < 10 && q.size() > 0; i++) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
        check(tag, a_out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit          acc;
        int          k;
        logic [31:0] bp[5];

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 64'h0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_a_out_valid", a_out_valid, 1'b0);
        check("rst_a_in_ready", a_in_ready, 1'b1);
        check("rst_a_cnt", a_cnt, 0);
        check("rst_a_imm", a_imm, 0);
        check("rst_b_alu", b_alu, 0);
        check("rst_b_pc", b_pc, 0);
        rst = 1'b0;
        @(negedge clk);

        // Decode sweep of the named instructions.
        cycle(1'b1, 32'h403100B3, 64'h1000, 1'b1, 1'b0, acc);
        check("sub_a_alu", a_alu, 2);
        check("sub_b_alu", b_alu, 2);
        cycle(1'b1, 32'h40315093, 64'h1004, 1'b1, 1'b0, acc);
        check("srai_a_alu", a_alu, 8);
        check("srai_a_imm", a_imm, 3);
        check("srai_b_imm", b_imm, 3);
        cycle(1'b1, 32'hFE310EE3, 64'h1008, 1'b1, 1'b0, acc);
        check("beq_a_alu", a_alu, 2);
        check("beq_a_br", a_br, 1);
        check("beq_a_imm", a_imm, 64'h0000_0000_FFFF_FFFC);
        check("beq_b_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1'b1, 32'h023100B3, 64'h100C, 1'b1, 1'b0, acc);
        check("mul_a_illegal", a_ill, 1'b1);
        check("mul_a_cnt", a_cnt, 1);
        check("mul_b_alu", b_alu, 11);
        check("mul_b_cnt", b_cnt, 0);
        cycle(1'b1, 32'h02011093, 64'h1010, 1'b1, 1'b0, acc);
        check("slli32_a_illegal", a_ill, 1'b1);
        check("slli32_b_alu", b_alu, 3);
        check("slli32_b_imm", b_imm, 32);
        drain_all("sweep_drained");

        // Backpressure: out_ready low for the first three cycles.
        bp = '{32'h002081B3, 32'h00A10113, 32'h00412183, 32'h00312223, 32'h00209463};
        k = 0;
        for (int c = 0; c < 40 && k < 5; c++) begin
            cycle(1'b1, bp[k], 64'h2000 + 64'(k * 4), c >= 3, 1'b0, acc);
            if (acc) k++;
            if (c == 1) check("bp_in_ready_low", a_in_ready, 1'b0);
        end
        check("bp_all_accepted", k, 5);
        drain_all("bp_drained");

        // Flush from FULL2 with an illegal instruction presented.
        cycle(1'b1, 32'h00100093, 64'h3000, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h00200113, 64'h3004, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'hFFFFFFFF, 64'h3008, 1'b1, 1'b1, acc);
        check("flush_out_valid", a_out_valid, 1'b0);
        check("flush_in_ready", a_in_ready, 1'b1);
        check("flush_not_counted", a_cnt, cnt_a);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom() % 4) != 0, rand_instr(), {$urandom(), $urandom()} & ~64'h3,
                  ($urandom() % 10) < 7, ($urandom() % 40) == 0, acc);
        end
        drain_all("rand_drained");

        // Saturation of the narrow counter.
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'hFFFFFFFF, 64'h4000, 1'b1, 1'b0, acc);
        check("sat_a_cnt", a_cnt, 15);
        drain_all("sat_drained");

        // Asynchronous reset in the middle of a full buffer.
        cycle(1'b1, 32'h00100093, 64'h5000, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h00200113, 64'h5004, 1'b0, 1'b0, acc);
        #2 rst = 1'b1;
        #1;
        check("midrst_a_out_valid", a_out_valid, 1'b0);
        check("midrst_a_in_ready", a_in_ready, 1'b1);
        check("midrst_a_cnt", a_cnt, 0);
        check("midrst_b_cnt", b_cnt, 0);
        check("midrst_b_out_valid", b_out_valid, 1'b0);
        check("midrst_a_alu", a_alu, 0);
        q.delete();
        cnt_a = 0;
        cnt_b = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle(($urandom() % 2) != 0, rand_instr(), {$urandom(), $urandom()} & ~64'h3,
                  ($urandom() % 2) != 0, 1'b0, acc);
        end
        drain_all("post_rst_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
